// File: rtl/buffer_vc.sv
// Multi-VC flit buffer: NUM_VC independent FWFT queues sharing one write and one read port.
// Optional sticky overflow/underflow flags are built when BUFFER_VC_ERR_EN is defined.
module buffer_vc #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 4,
    parameter int NUM_VC   = 2,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int VCW     = (NUM_VC > 2) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEnable,
    input  logic [VCW-1:0]    wrVc,
    input  logic [WIDTH-1:0]  dataIn,
    input  logic              rdEnable,
    input  logic [VCW-1:0]    rdVc,
    output logic [WIDTH-1:0]  dataOut,
    output logic [NUM_VC-1:0] full,
    output logic [NUM_VC-1:0] empty,
`ifdef BUFFER_VC_ERR_EN
    output logic [NUM_VC-1:0] overflow,
    output logic [NUM_VC-1:0] underflow,
`endif
    output logic [NUM_VC-1:0] almostFull
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                     wr_vc_ok;
    logic                     rd_vc_ok;
    logic [VCW-1:0]           wr_idx;
    logic [VCW-1:0]           rd_idx;
    logic                     rd_ok;
    logic                     wr_ok;
    logic [NUM_VC-1:0]        wr_hit;
    logic [NUM_VC-1:0]        rd_hit;
    logic [NUM_VC*WIDTH-1:0]  heads;

    // Accept logic: out-of-range VCs are rejected, pass-through allowed at full
    always_comb begin
        wr_vc_ok = {1'b0, wrVc} < (VCW+1)'(NUM_VC);
        rd_vc_ok = {1'b0, rdVc} < (VCW+1)'(NUM_VC);
        wr_idx   = wr_vc_ok ? wrVc : '0;
        rd_idx   = rd_vc_ok ? rdVc : '0;
        rd_ok    = rdEnable && rd_vc_ok && !empty[rd_idx];
        wr_ok    = wrEnable && wr_vc_ok &&
                   (!full[wr_idx] ||
                    (rd_ok && (rd_idx == wr_idx)));
        for (int v = 0; v < NUM_VC; v++) begin
            wr_hit[v] = wr_ok && (wr_idx == VCW'(v));
            rd_hit[v] = rd_ok && (rd_idx == VCW'(v));
        end
    end

    // Head of the selected VC, zero-latency fall-through
    always_comb begin
        dataOut = heads[WIDTH-1:0];
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_idx == VCW'(v)) begin
                dataOut = heads[v*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    rd_ptr_q;
        logic [PW-1:0]    rd_ptr_d;
        logic [PW-1:0]    wr_ptr_q;
        logic [PW-1:0]    wr_ptr_d;
        logic [CW-1:0]    cnt_q;
        logic [CW-1:0]    cnt_d;

        // Pointer and occupancy next state for this VC
        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
            if (wr_hit[v]) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_hit[v]) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_hit[v], rd_hit[v]})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Pointer and occupancy registers, cleared asynchronously
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Flit storage, intentionally left out of reset
        always_ff @(posedge clk) begin
            if (wr_hit[v]) begin
                mem_q[wr_ptr_q] <= dataIn;
            end
        end

        assign heads[v*WIDTH +: WIDTH] = mem_q[rd_ptr_q];
        assign full[v]       = (cnt_q == CW'(DEPTH));
        assign empty[v]      = (cnt_q == '0);
        assign almostFull[v] = (cnt_q >= CW'(AF_LEVEL));

`ifdef BUFFER_VC_ERR_EN
        logic ovf_q;
        logic ovf_d;
        logic unf_q;
        logic unf_d;

        // Sticky error flags for dropped writes and empty reads
        always_comb begin
            ovf_d = ovf_q;
            unf_d = unf_q;
            if (wrEnable && wr_vc_ok &&
                (wr_idx == VCW'(v)) && !wr_ok) begin
                ovf_d = 1'b1;
            end
            if (rdEnable && rd_vc_ok &&
                (rd_idx == VCW'(v)) && empty[v]) begin
                unf_d = 1'b1;
            end
        end

        // Error flag registers, cleared only by reset
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end

        assign overflow[v]  = ovf_q;
        assign underflow[v] = unf_q;
`endif
    end

endmodule
